// File: rtl/serial_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_arbiter: two-master, frame-atomic bus arbiter (master 0 wins)   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module serial_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       frame_active_i,
  output logic [1:0] gnt_o,
  output logic       msel_o,
  output logic       split_pending_o,
  output logic [1:0] split_owner_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MASTER0 = 2'b01,
    ST_MASTER1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The current owner keeps the bus until its frame ends and its request drops.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_i[0]) begin
          w_state_next = ST_MASTER0;
        end else if (req_i[1]) begin
          w_state_next = ST_MASTER1;
        end
      end
      ST_MASTER0: begin
        if (!frame_active_i && !req_i[0]) begin
          w_state_next = req_i[1] ? ST_MASTER1 : ST_IDLE;
        end
      end
      ST_MASTER1: begin
        if (!frame_active_i && !req_i[1]) begin
          w_state_next = req_i[0] ? ST_MASTER0 : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs depend only on the state register, so reset clears them at once.
  assign gnt_o           = {r_state == ST_MASTER1, r_state == ST_MASTER0};
  assign msel_o          = (r_state == ST_MASTER1);
  assign split_pending_o = 1'b0;
  assign split_owner_o   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_serial_arbiter.sv
`default_nettype none
// Directed testbench for serial_arbiter.
module tb_serial_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       frame_active;
  logic [1:0] gnt;
  logic       msel;
  logic       split_pending;
  logic [1:0] split_owner;

  int errors = 0;
  int checks = 0;

  serial_arbiter u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .frame_active_i  (frame_active),
    .gnt_o           (gnt),
    .msel_o          (msel),
    .split_pending_o (split_pending),
    .split_owner_o   (split_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks grant, mux select and the inactive split outputs against one expected grant.
  task automatic expect_gnt(input string tag, input logic [1:0] exp_gnt);
    logic exp_msel;
    exp_msel = (exp_gnt == 2'b10);
    check({tag, ".gnt"}, {6'd0, gnt}, {6'd0, exp_gnt});
    check({tag, ".msel"}, {7'd0, msel}, {7'd0, exp_msel});
    check({tag, ".split_pend"}, {7'd0, split_pending}, 8'd0);
    check({tag, ".split_own"}, {6'd0, split_owner}, 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    frame_active = 1'b0;
    step();
    step();
    expect_gnt("reset", 2'b00);
    rst = 1'b0;

    // Master 0 basic grant, frame hold, back-to-back keep, release
    req = 2'b01;
    step(); expect_gnt("m0_grant", 2'b01);
    frame_active = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); expect_gnt("m0_frame", 2'b01); end
    frame_active = 1'b0;
    step(); expect_gnt("m0_keep", 2'b01);
    req = 2'b00;
    step(); expect_gnt("m0_release", 2'b00);

    // Frame active while idle is ignored
    frame_active = 1'b1;
    step(); expect_gnt("idle_frame", 2'b00);
    frame_active = 1'b0;

    // Master 1 grant through a frame
    req = 2'b10;
    step(); expect_gnt("m1_grant", 2'b10);
    frame_active = 1'b1;
    for (int i = 0; i < 2; i++) begin step(); expect_gnt("m1_frame", 2'b10); end
    frame_active = 1'b0;
    req = 2'b00;
    step(); expect_gnt("m1_release", 2'b00);

    // Simultaneous request: master 0 priority, then direct handover
    req = 2'b11;
    step(); expect_gnt("prio", 2'b01);
    frame_active = 1'b1;
    step(); expect_gnt("prio_frame", 2'b01);
    frame_active = 1'b0;
    req = 2'b10;
    step(); expect_gnt("handover_1", 2'b10);
    step(); expect_gnt("handover_2", 2'b10);
    req = 2'b00;
    step(); expect_gnt("handover_rel", 2'b00);

    // No release mid-frame, even with both requesting or master 0 dropping
    req = 2'b01;
    step(); expect_gnt("atomic_grant", 2'b01);
    frame_active = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin step(); expect_gnt("atomic_frame", 2'b01); end
    req = 2'b10;
    step(); expect_gnt("atomic_drop", 2'b01);
    frame_active = 1'b0;
    step(); expect_gnt("atomic_hand", 2'b10);

    // Master 1 owner not preempted by master 0, then hands back to master 0
    req = 2'b11;
    step(); expect_gnt("no_preempt", 2'b10);
    req = 2'b01;
    step(); expect_gnt("m1_to_m0", 2'b01);
    req = 2'b00;
    step(); expect_gnt("m0_idle", 2'b00);

    // Master 0 back-to-back frames
    req = 2'b01;
    step(); expect_gnt("b2b_grant", 2'b01);
    frame_active = 1'b1; step(); expect_gnt("b2b_f1a", 2'b01);
    step(); expect_gnt("b2b_f1b", 2'b01);
    frame_active = 1'b0; step(); expect_gnt("b2b_gap", 2'b01);
    frame_active = 1'b1; step(); expect_gnt("b2b_f2a", 2'b01);
    step(); expect_gnt("b2b_f2b", 2'b01);
    frame_active = 1'b0;
    req = 2'b00;
    step(); expect_gnt("b2b_release", 2'b00);

    // Asynchronous reset while master 1 owns the bus mid-frame
    req = 2'b10;
    step(); expect_gnt("ar_grant", 2'b10);
    frame_active = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    expect_gnt("async_rst", 2'b00);
    step(); expect_gnt("rst_hold", 2'b00);
    rst = 1'b0;
    frame_active = 1'b0;
    req = 2'b00;
    step(); expect_gnt("post_rst", 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_arbiter.md
Name: serial_arbiter

Overview:
- Two-master bus arbiter for the serial bus fabric.
- Grants the shared bus to one of two masters (master 0 has fixed priority) and holds the grant for an entire frame (frame-atomic).
- Drives the master-select mux control for the datapath.
- Split-transaction status outputs are present for interface compatibility; they are held inactive in this revision.

Parameters:
- None.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  2  bus request; bit0 = master 0, bit1 = master 1.
- gnt_o  output  2  one-hot registered grant; bit0 = master 0, bit1 = master 1; 00 = bus idle.
- frame_active_i  input  1  high while the current owner's frame is in progress on the bus.
- msel_o  output  1  master select: 1 when master 1 is granted, else 0.
- split_pending_o  output  1  split transaction pending; constant 0 in this revision.
- split_owner_o  output  2  owner of the pending split; constant 00 in this revision.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state IDLE, gnt_o=00, msel_o=0, split_pending_o=0, split_owner_o=00. Reset mid-operation drops any grant immediately (asynchronously).
- FSM states: IDLE, MASTER0, MASTER1. gnt_o and msel_o decode directly from the state register: no combinational path from req_i or frame_active_i to the outputs.
- Latency: a grant change is visible one clock edge after the inputs that cause it.
- IDLE:
  - req_i[0]=1 -> MASTER0 (priority, including req_i=11).
  - else req_i[1]=1 -> MASTER1.
  - else stay IDLE.
- MASTER0:
  - frame_active_i=1 -> stay, regardless of req_i (frame-atomic; no preemption, no release mid-frame).
  - frame_active_i=0 and req_i[0]=1 -> stay (owner keeps bus; back-to-back frames allowed without re-arbitration).
  - frame_active_i=0, req_i[0]=0, req_i[1]=1 -> MASTER1 directly (single-cycle handover, no IDLE bubble).
  - frame_active_i=0, req_i=00 -> IDLE.
- MASTER1: symmetric to MASTER0. While frame_active_i=0 and req_i[1]=1, stay even if req_i[0]=1; the owner is not preempted by the higher-priority master. On release, hand over to MASTER0 if req_i[0]=1, else go to IDLE.
- gnt_o is never 11. msel_o=1 only in MASTER1; it is 0 in IDLE and MASTER0.
- frame_active_i asserted while IDLE is ignored.

Test Plan:
- Reset, then req=01 -> next edge gnt=01, msel=0. Hold frame_active=1 for 3 cycles -> gnt=01. Drop frame, keep req -> gnt=01. req=00 -> next edge gnt=00.
- req=10 from idle -> gnt=10, msel=1; held through a frame. req=00 -> gnt=00, msel=0.
- req=11 from idle -> gnt=01. After the frame, req=10 -> gnt=10, msel=1 within 1 edge and still 10 after 2 edges.
- Master 0 granted, frame_active=1, req changes to 11 for 3 cycles -> gnt stays 01. frame_active=0, then req=10 -> gnt=10 next edge.
- Master 0 with two back-to-back frames (frame high 2 cycles, low 1, high 2) and req held -> gnt=01 throughout. req=00 -> gnt=00.
- Assert rst_i while gnt=10 -> gnt=00 and msel=0 immediately, without waiting for a clock edge. split_pending_o=0 and split_owner_o=00 in all scenarios.
